// File: rtl/dmem_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder_if
// Brief    : Request/response handshake and SRAM port bundle for dmem_responder
// Revision : 1.0  initial release
// ============================================================================
`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 12
`endif

interface dmem_responder_if #(
  parameter int MEM_ADDR_WIDTH = `MEM_ADDR_WIDTH
);
  logic                      req_valid;
  logic                      req_ready;
  logic                      req_we;
  logic [1:0]                req_size;
  logic [MEM_ADDR_WIDTH-1:0] req_addr;
  logic [31:0]               req_wdata;
  logic                      resp_valid;
  logic                      resp_ready;
  logic [31:0]               resp_rdata;
  logic                      resp_err;
  logic                      mem_en;
  logic                      mem_we;
  logic [3:0]                mem_be;
  logic [MEM_ADDR_WIDTH-3:0] mem_addr;
  logic [31:0]               mem_wdata;
  logic [31:0]               mem_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_addr, req_wdata, resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_size, req_addr, req_wdata, resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );
endinterface

`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Brief    : Byte/half/word load-store responder over a word-wide sync SRAM,
//            splitting word-crossing accesses into two SRAM cycles
// Revision : 1.0  initial release
// ============================================================================
`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 12
`endif

module dmem_responder #(
  parameter int MEM_ADDR_WIDTH   = `MEM_ADDR_WIDTH,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input wire              clk,
  input wire              rst_n,
  dmem_responder_if.slave bus
);
  localparam int WORD_AW = MEM_ADDR_WIDTH - 2;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ACC0 = 3'd1,
    ACC1 = 3'd2,
    CAP  = 3'd3,
    RESP = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_we;
  logic [1:0]         r_size;
  logic [1:0]         r_off;
  logic [WORD_AW-1:0] r_w;
  logic [31:0]        r_wdata;
  logic [31:0]        r_lo;
  logic [23:0]        r_hi;
  logic               r_err;

  logic               w_misaligned;
  logic               w_req_err;
  logic [3:0]         w_nmask;
  logic [2:0]         w_nbytes;
  logic               w_split;
  logic [7:0]         w_be8;
  logic [63:0]        w_sh;
  logic [31:0]        w_algn;
  logic [31:0]        w_load;
  logic               w_acc;

  generate
    if (ALLOW_MISALIGNED) begin : g_misaligned_split
      assign w_misaligned = 1'b0;
    end else begin : g_misaligned_trap
      assign w_misaligned = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                            ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));
    end
  endgenerate

  assign w_req_err = (bus.req_size == 2'b11) || w_misaligned;

  always_comb begin
    w_nmask  = 4'b1111;
    w_nbytes = 3'd4;
    case (r_size)
      2'b00:   begin w_nmask = 4'b0001; w_nbytes = 3'd1; end
      2'b01:   begin w_nmask = 4'b0011; w_nbytes = 3'd2; end
      default: begin w_nmask = 4'b1111; w_nbytes = 3'd4; end
    endcase
  end

  assign w_split = (({1'b0, r_off} + w_nbytes) > 3'd4);
  assign w_be8   = {4'b0000, w_nmask} << r_off;
  assign w_sh    = {32'd0, r_wdata} << {r_off, 3'b000};

  // Only hi[23:0] can ever reach the result since the offset is at most 3.
  always_comb begin
    w_algn = r_lo;
    case (r_off)
      2'd1:    w_algn = {r_hi[7:0],  r_lo[31:8]};
      2'd2:    w_algn = {r_hi[15:0], r_lo[31:16]};
      2'd3:    w_algn = {r_hi[23:0], r_lo[31:24]};
      default: w_algn = r_lo;
    endcase
  end

  assign w_load = w_algn & {{8{w_nmask[3]}}, {8{w_nmask[2]}}, {8{w_nmask[1]}}, {8{w_nmask[0]}}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (bus.req_valid) w_next = w_req_err ? RESP : ACC0;
      ACC0: w_next = w_split ? ACC1 : (r_we ? RESP : CAP);
      ACC1: w_next = r_we ? RESP : CAP;
      CAP:  w_next = RESP;
      RESP: if (bus.resp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_size  <= 2'b00;
      r_off   <= 2'b00;
      r_w     <= '0;
      r_wdata <= '0;
      r_lo    <= '0;
      r_hi    <= '0;
      r_err   <= 1'b0;
    end else begin
      if ((r_state == IDLE) && bus.req_valid) begin
        r_we    <= bus.req_we;
        r_size  <= bus.req_size;
        r_off   <= bus.req_addr[1:0];
        r_w     <= bus.req_addr[MEM_ADDR_WIDTH-1:2];
        r_wdata <= bus.req_wdata;
        r_err   <= w_req_err;
      end
      // Read data lags the strobe by one cycle: ACC1 sees word w, CAP sees the last read.
      if ((r_state == ACC1) && !r_we) r_lo <= bus.mem_rdata;
      if (r_state == CAP) begin
        if (w_split) r_hi <= bus.mem_rdata[23:0];
        else         r_lo <= bus.mem_rdata;
      end
    end
  end

  assign w_acc = (r_state == ACC0) || (r_state == ACC1);

  always_comb begin
    bus.mem_en    = w_acc;
    bus.mem_we    = w_acc && r_we;
    bus.mem_be    = 4'h0;
    bus.mem_addr  = '0;
    bus.mem_wdata = 32'h0;
    if (r_state == ACC0) begin
      bus.mem_addr = r_w;
      bus.mem_be   = r_we ? w_be8[3:0] : 4'hF;
      if (r_we) bus.mem_wdata = w_sh[31:0];
    end else if (r_state == ACC1) begin
      bus.mem_addr = r_w + WORD_AW'(1);
      bus.mem_be   = r_we ? w_be8[7:4] : 4'hF;
      if (r_we) bus.mem_wdata = w_sh[63:32];
    end
  end

  assign bus.req_ready  = (r_state == IDLE);
  assign bus.resp_valid = (r_state == RESP);
  assign bus.resp_err   = (r_state == RESP) && r_err;
  assign bus.resp_rdata = ((r_state == RESP) && !r_we && !r_err) ? w_load : 32'h0;

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Brief    : Directed vector bench for dmem_responder with a behavioural SRAM
// Revision : 1.0  initial release
// ============================================================================
module tb_dmem_responder;
  localparam int AW = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  dmem_responder_if #(.MEM_ADDR_WIDTH(AW)) bus_a ();
  dmem_responder_if #(.MEM_ADDR_WIDTH(AW)) bus_b ();

  dmem_responder #(.MEM_ADDR_WIDTH(AW), .ALLOW_MISALIGNED(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
  dmem_responder #(.MEM_ADDR_WIDTH(AW), .ALLOW_MISALIGNED(1'b0)) u_dut_strict (
    .clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

  logic          req_valid, req_we, resp_ready, use_b;
  logic [1:0]    req_size;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;

  assign bus_a.req_valid  = req_valid && !use_b;
  assign bus_b.req_valid  = req_valid && use_b;
  assign bus_a.req_we     = req_we;
  assign bus_b.req_we     = req_we;
  assign bus_a.req_size   = req_size;
  assign bus_b.req_size   = req_size;
  assign bus_a.req_addr   = req_addr;
  assign bus_b.req_addr   = req_addr;
  assign bus_a.req_wdata  = req_wdata;
  assign bus_b.req_wdata  = req_wdata;
  assign bus_a.resp_ready = resp_ready;
  assign bus_b.resp_ready = resp_ready;
  assign bus_b.mem_rdata  = 32'h0;

  logic        obs_valid, obs_err, obs_ready;
  logic [31:0] obs_rdata;
  assign obs_valid = use_b ? bus_b.resp_valid : bus_a.resp_valid;
  assign obs_err   = use_b ? bus_b.resp_err   : bus_a.resp_err;
  assign obs_ready = use_b ? bus_b.req_ready  : bus_a.req_ready;
  assign obs_rdata = use_b ? bus_b.resp_rdata : bus_a.resp_rdata;

  // Behavioural SRAM: one-cycle read latency, byte-enabled writes
  logic [31:0] sram [0:1023];
  logic [31:0] sram_q;
  always @(posedge clk) begin
    if (bus_a.mem_en) begin
      if (bus_a.mem_we) begin
        for (int i = 0; i < 4; i++)
          if (bus_a.mem_be[i]) sram[bus_a.mem_addr][8*i +: 8] <= bus_a.mem_wdata[8*i +: 8];
      end else begin
        sram_q <= sram[bus_a.mem_addr];
      end
    end
  end
  assign bus_a.mem_rdata = sram_q;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  int          lat, en_cnt;
  logic [31:0] got_rdata;
  logic        got_err;
  logic        cyc_en    [1:4];
  logic        cyc_we    [1:4];
  logic [3:0]  cyc_be    [1:4];
  logic [31:0] cyc_addr  [1:4];
  logic [31:0] cyc_wdata [1:4];

  // Issue one request and wait (bounded) for its response with resp_ready high.
  task automatic run_req(input logic b, input logic we, input logic [1:0] size,
                         input logic [AW-1:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    use_b = b; req_we = we; req_size = size; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1; resp_ready = 1'b1;
    lat = 0; en_cnt = 0;
    for (int k = 1; k <= 4; k++) begin
      cyc_en[k] = 1'b0; cyc_we[k] = 1'b0; cyc_be[k] = 4'h0; cyc_addr[k] = 0; cyc_wdata[k] = 0;
    end
    do begin
      @(negedge clk);
      req_valid = 1'b0;
      lat++;
      if (bus_a.mem_en) en_cnt++;
      if (lat <= 4) begin
        cyc_en[lat] = bus_a.mem_en; cyc_we[lat] = bus_a.mem_we; cyc_be[lat] = bus_a.mem_be;
        cyc_addr[lat] = 32'(bus_a.mem_addr); cyc_wdata[lat] = bus_a.mem_wdata;
      end
    end while (!obs_valid && lat < 20);
    got_rdata = obs_rdata;
    got_err   = obs_err;
    if (!obs_valid) begin
      n_checks++; n_errors++;
      $display("FAIL timeout: no resp_valid for addr 0x%03h within %0d cycles", addr, lat);
    end
  endtask

  typedef struct {
    logic          we;
    logic [1:0]    size;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [31:0]   exp_rdata;
    logic          exp_err;
    int            exp_lat;
  } vec_t;
  vec_t vecs [17];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; use_b = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_addr = '0; req_wdata = 32'h0; resp_ready = 1'b1; sram_q = 32'h0;
    for (int i = 0; i < 1024; i++) sram[i] = 32'h0;
    sram[10'h080] = 32'hDEADBEEF;
    sram[10'h3FF] = 32'h12345678;
    sram[10'h000] = 32'h9ABCDEF0;

    vecs[0]  = '{1'b0, 2'b10, 12'h200, 32'h0,        32'hDEADBEEF, 1'b0, 3};
    vecs[1]  = '{1'b0, 2'b01, 12'h202, 32'h0,        32'h0000DEAD, 1'b0, 3};
    vecs[2]  = '{1'b0, 2'b00, 12'h201, 32'h0,        32'h000000BE, 1'b0, 3};
    vecs[3]  = '{1'b0, 2'b00, 12'h203, 32'h0,        32'h000000DE, 1'b0, 3};
    vecs[4]  = '{1'b0, 2'b01, 12'h201, 32'h0,        32'h0000ADBE, 1'b0, 3};
    vecs[5]  = '{1'b0, 2'b01, 12'h107, 32'h0,        32'h00002233, 1'b0, 4};
    vecs[6]  = '{1'b0, 2'b10, 12'h105, 32'h0,        32'h22334400, 1'b0, 4};
    vecs[7]  = '{1'b1, 2'b01, 12'h1FF, 32'h0000CAFE, 32'h0,        1'b0, 3};
    vecs[8]  = '{1'b0, 2'b10, 12'h200, 32'h0,        32'hDEADBECA, 1'b0, 3};
    vecs[9]  = '{1'b0, 2'b01, 12'h1FF, 32'h0,        32'h0000CAFE, 1'b0, 4};
    vecs[10] = '{1'b0, 2'b11, 12'h000, 32'h0,        32'h0,        1'b1, 1};
    vecs[11] = '{1'b1, 2'b10, 12'h300, 32'h89ABCDEF, 32'h0,        1'b0, 2};
    vecs[12] = '{1'b0, 2'b00, 12'h302, 32'h0,        32'h000000AB, 1'b0, 3};
    vecs[13] = '{1'b1, 2'b00, 12'h301, 32'hFFFFFF5A, 32'h0,        1'b0, 2};
    vecs[14] = '{1'b0, 2'b10, 12'h300, 32'h0,        32'h89AB5AEF, 1'b0, 3};
    vecs[15] = '{1'b1, 2'b11, 12'h300, 32'hFFFFFFFF, 32'h0,        1'b1, 1};
    vecs[16] = '{1'b0, 2'b10, 12'h300, 32'h0,        32'h89AB5AEF, 1'b0, 3};

    #12;
    check("rst_ctrl", 32'({bus_a.req_ready, bus_a.resp_valid, bus_a.resp_err,
                          bus_a.mem_en, bus_a.mem_we, bus_a.mem_be}), 32'h100);
    check("rst_rdata", bus_a.resp_rdata, 32'h0);
    check("rst_maddr", 32'(bus_a.mem_addr), 32'h0);
    check("rst_mwdata", bus_a.mem_wdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Aligned byte store into the top lane
    run_req(1'b0, 1'b1, 2'b00, 12'h103, 32'h000000A5);
    check("sb_lat", lat, 2);
    check("sb_en_we", {cyc_en[1], cyc_we[1]}, 2'b11);
    check("sb_addr", cyc_addr[1], 32'h40);
    check("sb_be", cyc_be[1], 4'b1000);
    check("sb_wdata", cyc_wdata[1], 32'hA5000000);
    check("sb_err", got_err, 1'b0);

    // Split word store then read it back
    run_req(1'b0, 1'b1, 2'b10, 12'h106, 32'h11223344);
    check("sw_lat", lat, 3);
    check("sw_a0", cyc_addr[1], 32'h41);
    check("sw_be0", cyc_be[1], 4'b1100);
    check("sw_wd0", cyc_wdata[1], 32'h33440000);
    check("sw_a1", cyc_addr[2], 32'h42);
    check("sw_be1", cyc_be[2], 4'b0011);
    check("sw_wd1", cyc_wdata[2], 32'h00001122);
    check("sw_en_cnt", en_cnt, 2);
    run_req(1'b0, 1'b0, 2'b10, 12'h106, 32'h0);
    check("lw106_lat", lat, 4);
    check("lw106_rdata", got_rdata, 32'h11223344);
    check("lw106_rd_be", {cyc_we[1], cyc_be[1]}, 5'b01111);

    for (int i = 0; i < 17; i++) begin
      run_req(1'b0, vecs[i].we, vecs[i].size, vecs[i].addr, vecs[i].wdata);
      check($sformatf("v%0d_rdata", i), got_rdata, vecs[i].exp_rdata);
      check($sformatf("v%0d_err", i), got_err, vecs[i].exp_err);
      check($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
      if (vecs[i].exp_err) check($sformatf("v%0d_no_mem", i), en_cnt, 0);
    end

    // Halfword at the last byte address wraps to word 0
    run_req(1'b0, 1'b0, 2'b01, 12'hFFF, 32'h0);
    check("top_a0", cyc_addr[1], 32'h3FF);
    check("top_a1", cyc_addr[2], 32'h000);
    check("top_rdata", got_rdata, 32'h0000F012);
    check("top_lat", lat, 4);

    // Response back-pressure, with a request already waiting
    @(negedge clk);
    use_b = 1'b0; req_we = 1'b0; req_size = 2'b10; req_addr = 12'h200;
    req_valid = 1'b1; resp_ready = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      req_valid = 1'b0;
      lat++;
    end while (!obs_valid && lat < 20);
    check("stall_lat", lat, 3);
    req_size = 2'b00; req_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("stall%0d_valid", c), obs_valid, 1'b1);
      check($sformatf("stall%0d_rdata", c), obs_rdata, 32'hDEADBECA);
      check($sformatf("stall%0d_ready", c), obs_ready, 1'b0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    check("hs_valid_low", obs_valid, 1'b0);
    check("hs_ready_high", obs_ready, 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
    check("next_acc_en", {bus_a.mem_en, obs_ready}, 2'b10);
    lat = 1;
    while (!obs_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("next_lat", lat, 3);
    check("next_rdata", obs_rdata, 32'h000000CA);

    // Reset during the second beat of a split store
    @(negedge clk);
    req_we = 1'b1; req_size = 2'b10; req_addr = 12'h2FE; req_wdata = 32'h55667788;
    req_valid = 1'b1; resp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check("rst_acc0_en", bus_a.mem_en, 1'b1);
    @(negedge clk);
    check("rst_acc1_addr", 32'(bus_a.mem_addr), 32'h0C0);
    rst_n = 1'b0;
    #1;
    check("rst_en_drop", bus_a.mem_en, 1'b0);
    check("rst_ready", bus_a.req_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("rst_noresp%0d", c), {bus_a.resp_valid, bus_a.req_ready}, 2'b01);
    end
    run_req(1'b0, 1'b0, 2'b10, 12'h2FC, 32'h0);
    check("rst_first_word", got_rdata, 32'h77880000);
    run_req(1'b0, 1'b0, 2'b10, 12'h300, 32'h0);
    check("rst_second_word", got_rdata, 32'h89AB5AEF);

    // Instance that traps misaligned accesses
    run_req(1'b1, 1'b0, 2'b10, 12'h102, 32'h0);
    check("strict_lw_err", got_err, 1'b1);
    check("strict_lw_lat", lat, 1);
    run_req(1'b1, 1'b0, 2'b01, 12'h201, 32'h0);
    check("strict_lh_odd_err", got_err, 1'b1);
    run_req(1'b1, 1'b0, 2'b01, 12'h202, 32'h0);
    check("strict_lh_ok_err", got_err, 1'b0);
    check("strict_lh_ok_lat", lat, 3);
    run_req(1'b1, 1'b1, 2'b00, 12'h103, 32'h0);
    check("strict_sb_err", got_err, 1'b0);
    check("strict_sb_lat", lat, 2);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

`default_nettype wire
